read_write_ram: RTL and testbench



---
 rtl/read_write_ram.sv | 90 +++++++++
 tb/tb_read_write_ram.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/read_write_ram.sv
// RAM smoke-test block: on start, writes TEST_DATA to TEST_ADDR,
// reads it back, and raises a sticky done with a match flag.
module read_write_ram #(
  parameter int unsigned                DATA_WIDTH = 16,
  parameter int unsigned                ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0]      TEST_ADDR  = 4'd3,
  parameter logic [DATA_WIDTH-1:0]      TEST_DATA  = 16'hA5C3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  match
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic                  done_q, done_d;
  logic                  match_q, match_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  we;

  assign mem_rd = mem[TEST_ADDR];
  assign we     = !rst && (state_q == WRITE);

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    match_d = match_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end
      WRITE: begin
        state_d = READ;
      end
      READ: begin
        state_d = IDLE;
        rdata_d = mem_rd;
        done_d  = 1'b1;
        match_d = (mem_rd == TEST_DATA);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      match_q <= match_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; only the test word is ever written
  always_ff @(posedge clk) begin
    if (we) begin
      mem[TEST_ADDR] <= TEST_DATA;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign match     = match_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_read_write_ram.sv
// Bench for read_write_ram: stimulus pushes expected completions,
// a monitor pops them on each rising done.
module tb_read_write_ram;

  typedef struct packed {
    logic [15:0] data;
    logic        match;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic        done;
  logic [15:0] read_data;
  logic        match;

  int   checks;
  int   errors;
  exp_t exp_q [$];

  read_write_ram dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .done      (done),
    .read_data (read_data),
    .match     (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    exp_t e;
    e.data  = 16'hA5C3;
    e.match = 1'b1;
    exp_q.push_back(e);
  endtask

  // completion monitor
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_read_data", 32'(read_data), 32'(e.data));
          chk("mon_match", 32'(match), 32'(e.match));
        end
      end
      prev = done;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_read_data", 32'(read_data), 32'd0);
    step();

    // basic run
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    chk("basic_e0_ready", 32'(ready), 32'd0);
    chk("basic_e0_done", 32'(done), 32'd0);
    step();
    chk("basic_e1_ready", 32'(ready), 32'd0);
    chk("basic_e1_done", 32'(done), 32'd0);
    step();
    chk("basic_e2_done", 32'(done), 32'd1);
    chk("basic_e2_ready", 32'(ready), 32'd1);
    chk("basic_e2_data", 32'(read_data), 32'hA5C3);
    chk("basic_e2_match", 32'(match), 32'd1);

    // sticky done
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sticky_done", 32'(done), 32'd1);
      chk("sticky_ready", 32'(ready), 32'd1);
    end

    // starts while busy are dropped
    start = 1'b1;
    push_run();
    step();
    chk("busy_accept_done", 32'(done), 32'd0);
    start = 1'b1;
    step();
    chk("busy_write_ready", 32'(ready), 32'd0);
    start = 1'b1;
    step();
    chk("busy_read_done", 32'(done), 32'd1);
    chk("busy_read_ready", 32'(ready), 32'd1);
    start = 1'b0;
    step();
    chk("busy_after_ready", 32'(ready), 32'd1);
    chk("busy_after_done", 32'(done), 32'd1);
    step();
    chk("busy_after2_ready", 32'(ready), 32'd1);

    // reset mid-operation
    start = 1'b1;
    step();
    start = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_match", 32'(match), 32'd0);
    chk("midrst_data", 32'(read_data), 32'd0);
    step();
    chk("midrst_idle_done", 32'(done), 32'd0);
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    chk("rerun_e0_done", 32'(done), 32'd0);
    step();
    chk("rerun_e1_done", 32'(done), 32'd0);
    step();
    chk("rerun_e2_done", 32'(done), 32'd1);
    chk("rerun_e2_ready", 32'(ready), 32'd1);

    // back-to-back with start held for 7 edges
    start = 1'b1;
    push_run();
    push_run();
    push_run();
    for (int e = 0; e < 7; e++) begin
      step();
      chk($sformatf("b2b_done_e%0d", e), 32'(done),
          (e == 2 || e == 5) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_ready_e%0d", e), 32'(ready),
          (e == 2 || e == 5) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    step();
    chk("b2b_e7_done", 32'(done), 32'd0);
    step();
    chk("b2b_e8_done", 32'(done), 32'd1);
    chk("b2b_e8_match", 32'(match), 32'd1);
    step();
    step();
    chk("pending_completions", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
